draw_rect_flash: RTL and testbench

Downstream stage of the VGA background generator. It consumes that stage's registered timing bundle and background colour, and overlays a solid rectangle (the player sprite box) at a frame-synchronously latched position. It can blink the rectangle for a fixed number of periods on request. It forwards the timing bundle with matched latency to the next stage or the VGA pins.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/frame_tick.sv | 24 ++
 rtl/draw_rect_flash.sv | 208 ++++++++++++++++++++
 tb/tb_draw_rect_flash.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA overlay pipeline: bus widths, blink state
// encoding and the span test used by the rectangle hit logic.
package vga_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 11;
  localparam int RGB_W  = 12;

  typedef enum logic [1:0] {
    SHOW      = 2'b00,
    BLINK_OFF = 2'b01,
    BLINK_ON  = 2'b10
  } blink_state_e;

  // True when pos lies in [start, start+len). Operands are widened to 12 bits
  // by the caller so start+len cannot wrap for any 11-bit start.
  function automatic logic in_span(input logic [11:0] pos,
                                   input logic [11:0] start,
                                   input logic [11:0] len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Frame tick generator: a one-cycle pulse on the rising edge of v_blank.
// The history register resets high so reset itself never produces a tick;
// a fresh low-to-high transition of v_blank is required.
module frame_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic v_blank_i,
  output logic tick_o
);

  logic vblank_prev_q;

  // Remember the previous v_blank sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vblank_prev_q <= 1'b1;
    end else begin
      vblank_prev_q <= v_blank_i;
    end
  end

  assign tick_o = v_blank_i & ~vblank_prev_q;

endmodule

// File: rtl/draw_rect_flash.sv
// Rectangle overlay stage with optional blinking.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   SHOW      | rectangle drawn, idle, accepts flash_req
//   BLINK_OFF | rectangle hidden for FLASH_FRAMES frame ticks
//   BLINK_ON  | rectangle drawn for FLASH_FRAMES frame ticks
//
// Two pipeline stages: stage 1 captures the timing bundle, background
// colour, hit flag and visibility; stage 2 muxes the colour. Every output
// therefore lags its input by exactly two cycles.
module draw_rect_flash
  import vga_pkg::*;
#(
  parameter int               RECT_W       = 64,
  parameter int               RECT_H       = 48,
  parameter logic [RGB_W-1:0] RECT_COLOR   = 12'hff0,
  parameter int               FLASH_FRAMES = 8,
  parameter int               FLASH_COUNT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [VCNT_W-1:0] vcount_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              h_blank_in,
  input  logic              v_blank_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [HCNT_W-1:0] xpos,
  input  logic [VCNT_W-1:0] ypos,
  input  logic              flash_req,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [VCNT_W-1:0] vcount_out,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic              h_blank_out,
  output logic              v_blank_out,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              busy
);

  localparam logic [7:0]  FRAME_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [3:0]  PAIR_LAST  = 4'(FLASH_COUNT - 1);
  localparam logic [11:0] SPAN_W     = 12'(RECT_W);
  localparam logic [11:0] SPAN_H     = 12'(RECT_H);

  logic              tick;
  logic [HCNT_W-1:0] xpos_q;
  logic [VCNT_W-1:0] ypos_q;
  logic              inside_d;

  blink_state_e      state_q;
  logic [7:0]        frame_cnt_q;
  logic [3:0]        pair_cnt_q;
  logic              busy_q;
  logic              visible_q;

  logic [HCNT_W-1:0] s1_hcount_q;
  logic [VCNT_W-1:0] s1_vcount_q;
  logic              s1_h_sync_q;
  logic              s1_v_sync_q;
  logic              s1_h_blank_q;
  logic              s1_v_blank_q;
  logic [RGB_W-1:0]  s1_rgb_q;
  logic              s1_inside_q;
  logic              s1_visible_q;
  logic [RGB_W-1:0]  rgb_d;

  frame_tick u_frame_tick (
    .clk_i     (clk),
    .rst_i     (rst),
    .v_blank_i (v_blank_in),
    .tick_o    (tick)
  );

  // Position only moves at the start of vertical blanking, never mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else if (tick) begin
      xpos_q <= xpos;
      ypos_q <= ypos;
    end
  end

  assign inside_d = in_span({1'b0, hcount_in}, {1'b0, xpos_q}, SPAN_W) &&
                    in_span({1'b0, vcount_in}, {1'b0, ypos_q}, SPAN_H);

  // Blink sequencer; busy and visibility are registered alongside the state.
  // flash_req is only looked at in SHOW, so requests while busy are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SHOW;
      frame_cnt_q <= '0;
      pair_cnt_q  <= '0;
      busy_q      <= 1'b0;
      visible_q   <= 1'b1;
    end else begin
      case (state_q)
        SHOW: begin
          if (flash_req) begin
            state_q     <= BLINK_OFF;
            frame_cnt_q <= '0;
            pair_cnt_q  <= '0;
            busy_q      <= 1'b1;
            visible_q   <= 1'b0;
          end
        end
        BLINK_OFF: begin
          if (tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              state_q     <= BLINK_ON;
              frame_cnt_q <= '0;
              visible_q   <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        BLINK_ON: begin
          if (tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_q <= '0;
              if (pair_cnt_q == PAIR_LAST) begin
                state_q <= SHOW;
                busy_q  <= 1'b0;
              end else begin
                pair_cnt_q <= pair_cnt_q + 4'd1;
                state_q    <= BLINK_OFF;
                visible_q  <= 1'b0;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q     <= SHOW;
          frame_cnt_q <= '0;
          pair_cnt_q  <= '0;
          busy_q      <= 1'b0;
          visible_q   <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // Stage 1: capture the timing bundle together with hit and visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount_q  <= '0;
      s1_vcount_q  <= '0;
      s1_h_sync_q  <= 1'b0;
      s1_v_sync_q  <= 1'b0;
      s1_h_blank_q <= 1'b0;
      s1_v_blank_q <= 1'b0;
      s1_rgb_q     <= '0;
      s1_inside_q  <= 1'b0;
      s1_visible_q <= 1'b0;
    end else begin
      s1_hcount_q  <= hcount_in;
      s1_vcount_q  <= vcount_in;
      s1_h_sync_q  <= h_sync_in;
      s1_v_sync_q  <= v_sync_in;
      s1_h_blank_q <= h_blank_in;
      s1_v_blank_q <= v_blank_in;
      s1_rgb_q     <= rgb_in;
      s1_inside_q  <= inside_d;
      s1_visible_q <= visible_q;
    end
  end

  // Colour select: blanking forces black, then the rectangle, then background.
  always_comb begin
    rgb_d = s1_rgb_q;
    if (s1_h_blank_q || s1_v_blank_q) begin
      rgb_d = '0;
    end else if (s1_inside_q && s1_visible_q) begin
      rgb_d = RECT_COLOR;
    end
  end

  // Stage 2: register every output so all share the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      h_sync_out  <= 1'b0;
      v_sync_out  <= 1'b0;
      h_blank_out <= 1'b0;
      v_blank_out <= 1'b0;
      rgb_out     <= '0;
    end else begin
      hcount_out  <= s1_hcount_q;
      vcount_out  <= s1_vcount_q;
      h_sync_out  <= s1_h_sync_q;
      v_sync_out  <= s1_v_sync_q;
      h_blank_out <= s1_h_blank_q;
      v_blank_out <= s1_v_blank_q;
      rgb_out     <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_rect_flash.sv
// Scoreboard bench for draw_rect_flash: the driver pushes the expected output
// bundle for every cycle it drives, the monitor pops and compares it two
// cycles later on the falling edge.
module tb_draw_rect_flash;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
  logic        h_sync_in = 0, v_sync_in = 0, h_blank_in = 0, v_blank_in = 0;
  logic [11:0] rgb_in = '0;
  logic        flash_req = 0;
  logic [10:0] hcount_out, vcount_out;
  logic        h_sync_out, v_sync_out, h_blank_out, v_blank_out;
  logic [11:0] rgb_out;
  logic        busy;

  draw_rect_flash #(
    .FLASH_FRAMES(2),
    .FLASH_COUNT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .h_blank_in (h_blank_in),
    .v_blank_in (v_blank_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .flash_req  (flash_req),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .h_blank_out(h_blank_out),
    .v_blank_out(v_blank_out),
    .rgb_out    (rgb_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          chk;
    logic [37:0] exp;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;

  // Expected rectangle for the frame being driven, set by hand per test.
  int  m_ex = 0, m_ey = 0;
  bit  m_vis = 1;
  bit  g_busy_tick = 0, g_busy_end = 0;
  bit  g_move = 0;
  int  g_move_x = 0;

  int  lines[9]  = '{0, 47, 48, 199, 200, 220, 247, 248, 599};
  int  pix[16]   = '{0, 63, 64, 99, 100, 163, 164, 299, 300, 363, 364,
                     779, 780, 799, 800, 1000};
  bit  vis_tab[13] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare outputs against the entry due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      sb_t e;
      e = q.pop_front();
      if (e.due != cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_late @cyc %0d: due %0d", cyc, e.due);
      end else if (e.chk) begin
        n_chk++;
        if ({hcount_out, vcount_out, h_sync_out, v_sync_out,
             h_blank_out, v_blank_out, rgb_out} !== e.exp) begin
          n_err++;
          $display("FAIL pipe @cyc %0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                   cyc, hcount_out, vcount_out, h_sync_out, v_sync_out,
                   h_blank_out, v_blank_out, rgb_out,
                   e.exp[37:27], e.exp[26:16], e.exp[15], e.exp[14],
                   e.exp[13], e.exp[12], e.exp[11:0]);
        end
      end
    end
  end

  // Drive one pixel cycle and push its expected output bundle.
  task automatic px(input int h, input int v, input bit hs, input bit vs,
                    input bit hb, input bit vb, input logic [11:0] rgb,
                    input bit fl, input bit c);
    sb_t         e;
    bit          ins;
    logic [11:0] rgb_e;
    logic [10:0] hh, vv;
    hh = h[10:0];
    vv = v[10:0];
    hcount_in  = hh;
    vcount_in  = vv;
    h_sync_in  = hs;
    v_sync_in  = vs;
    h_blank_in = hb;
    v_blank_in = vb;
    rgb_in     = rgb;
    flash_req  = fl;
    ins = m_vis && (h >= m_ex) && (h < m_ex + 64) && (v >= m_ey) && (v < m_ey + 48);
    rgb_e = (hb || vb) ? 12'h000 : (ins ? 12'hff0 : rgb);
    e.due = cyc + 2;
    e.chk = c;
    e.exp = {hh, vv, hs, vs, hb, vb, rgb_e};
    q.push_back(e);
    @(posedge clk);
    #1;
    flash_req = 1'b0;
  endtask

  // One sparse frame: optional vblank prologue (frame tick on entry), then
  // selected lines and pixels around every boundary of interest.
  task automatic frame(input bit with_vb, input bit fl);
    if (with_vb) begin
      for (int i = 0; i < 4; i++) begin
        px(i, 600 + i, 1'b0, (i == 1 || i == 2), 1'b1, 1'b1, 12'h888, fl && (i == 1), 1'b1);
        if (i == 0) chk("busy_at_tick", {63'd0, busy}, {63'd0, g_busy_tick});
        if (i == 1 && fl) chk("busy_after_req", {63'd0, busy}, 64'd1);
      end
    end
    for (int li = 0; li < 9; li++) begin
      if (g_move && lines[li] == 220) xpos = g_move_x[10:0];
      for (int pi = 0; pi < 16; pi++) begin
        px(pix[pi], lines[li], pix[pi] == 1000, 1'b0, pix[pi] >= 800, 1'b0,
           12'h888, 1'b0, 1'b1);
      end
    end
    chk("busy_frame_end", {63'd0, busy}, {63'd0, g_busy_end});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {hcount_out, vcount_out, h_sync_out, v_sync_out,
                       h_blank_out, v_blank_out, rgb_out}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    px(0, 0, 0, 0, 1, 0, 12'h888, 0, 1);

    // Latch and colour at 100/200.
    xpos = 11'd100;
    ypos = 11'd200;
    m_ex = 100; m_ey = 200; m_vis = 1;
    frame(1, 0);

    // Move requested mid-frame: this frame stays at 100, the next at 300.
    g_move = 1; g_move_x = 300;
    frame(1, 0);
    g_move = 0;
    m_ex = 300;
    frame(1, 0);

    // Right-edge clipping at 780 on an 800-wide active area.
    xpos = 11'd780;
    m_ex = 780;
    frame(1, 0);

    // Blink: hidden 2, shown 2, three times; extra request in frame 5 ignored.
    xpos = 11'd100;
    m_ex = 100;
    for (int k = 0; k < 13; k++) begin
      m_vis       = vis_tab[k];
      g_busy_tick = (k >= 1 && k <= 11);
      g_busy_end  = (k <= 11);
      frame(1, (k == 0 || k == 5));
    end

    // Reset in BLINK_OFF while v_blank is high.
    xpos = 11'd300;
    m_ex = 300; m_vis = 0;
    g_busy_tick = 0; g_busy_end = 1;
    frame(1, 1);
    px(0, 600, 0, 0, 1, 1, 12'h888, 0, 1);
    chk("busy_pre_reset", {63'd0, busy}, 64'd1);
    px(1, 601, 0, 1, 1, 1, 12'h888, 0, 0);
    rst = 1'b1;
    px(2, 602, 0, 1, 1, 1, 12'h888, 0, 0);
    rst = 1'b0;
    chk("midrst_outs", {hcount_out, vcount_out, h_sync_out, v_sync_out,
                        h_blank_out, v_blank_out, rgb_out}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    m_ex = 0; m_ey = 0; m_vis = 1;
    for (int i = 3; i < 6; i++) px(i, 600 + i, 0, 0, 1, 1, 12'h888, 0, 1);
    g_busy_end = 0;
    frame(0, 0);
    m_ex = 300; m_ey = 200;
    frame(1, 0);

    // Latency alignment with a random timing stream.
    for (int i = 0; i < 200; i++) begin
      px($urandom_range(0, 2047), $urandom_range(0, 2047),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         12'($urandom), 0, 1);
    end

    px(0, 0, 0, 0, 1, 0, 12'h000, 0, 1);
    px(0, 0, 0, 0, 1, 0, 12'h000, 0, 1);
    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
